n_bit_serial_addsub: RTL and testbench

//  Parametrised digit-serial adder/subtractor. It is the sequential successor to the n-bit half adder.

---
 rtl/n_bit_serial_addsub.sv | 107 ++++++++++
 tb/tb_n_bit_serial_addsub.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/n_bit_serial_addsub.sv
// Digit-serial adder/subtractor: processes K bits per clock over N/K cycles,
// with the ripple carry held in a flop and a start/busy/done handshake.
module n_bit_serial_addsub #(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int DIGITS = N / K;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_opa;
  logic [N-1:0]   r_opb;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_sum;
  logic           r_cout;
  logic           r_ovf;
  logic           r_amsb;
  logic           r_bmsb;

  logic           w_accept;
  logic           w_last;
  logic [K:0]     w_dig;
  logic [N+K-1:0] w_cat;
  logic [N-1:0]   w_sum_nxt;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_cnt == CW'(DIGITS - 1));
  assign w_dig    = {1'b0, r_opa[K-1:0]} + {1'b0, r_opb[K-1:0]} + {{K{1'b0}}, r_carry};
  // New digit enters at the MSB end so after N/K shifts the result is in natural order.
  assign w_cat     = {w_dig[K-1:0], r_sum};
  assign w_sum_nxt = w_cat[N+K-1:K];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_amsb  <= 1'b0;
      r_bmsb  <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
      r_opa   <= A;
      r_opb   <= sub ? ~B : B;
      r_carry <= sub;
      r_cnt   <= '0;
      r_amsb  <= A[N-1];
      r_bmsb  <= sub ? ~B[N-1] : B[N-1];
    end else if (r_state == RUN) begin
      r_opa   <= r_opa >> K;
      r_opb   <= r_opb >> K;
      r_sum   <= w_sum_nxt;
      r_carry <= w_dig[K];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_dig[K];
        r_ovf  <= (r_amsb == r_bmsb) && (w_sum_nxt[N-1] != r_amsb);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_n_bit_serial_addsub.sv
// Scoreboard bench: one N=8/K=2 instance plus N=4 instances with K=1,2,4.
module tb_n_bit_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       st8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bz8, dn8, c8, o8;
  logic [7:0] s8;

  logic       st4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bz41, dn41, c41, o41, bz42, dn42, c42, o42, bz44, dn44, c44, o44;
  logic [3:0] s41, s42, s44;

  n_bit_serial_addsub #(.N(8), .K(2)) u8 (.clk(clk), .rst_n(rst_n), .start(st8), .sub(sub8),
    .A(a8), .B(b8), .busy(bz8), .done(dn8), .Sum(s8), .Cout(c8), .Ovf(o8));
  n_bit_serial_addsub #(.N(4), .K(1)) u41 (.clk(clk), .rst_n(rst_n), .start(st4), .sub(sub4),
    .A(a4), .B(b4), .busy(bz41), .done(dn41), .Sum(s41), .Cout(c41), .Ovf(o41));
  n_bit_serial_addsub #(.N(4), .K(2)) u42 (.clk(clk), .rst_n(rst_n), .start(st4), .sub(sub4),
    .A(a4), .B(b4), .busy(bz42), .done(dn42), .Sum(s42), .Cout(c42), .Ovf(o42));
  n_bit_serial_addsub #(.N(4), .K(4)) u44 (.clk(clk), .rst_n(rst_n), .start(st4), .sub(sub4),
    .A(a4), .B(b4), .busy(bz44), .done(dn44), .Sum(s44), .Cout(c44), .Ovf(o44));

  logic [3:0] dn, bz, co, ov;
  logic [7:0] sm [4];
  assign dn = {dn44, dn42, dn41, dn8};
  assign bz = {bz44, bz42, bz41, bz8};
  assign co = {c44, c42, c41, c8};
  assign ov = {o44, o42, o41, o8};
  assign sm[0] = s8;
  assign sm[1] = {4'b0, s41};
  assign sm[2] = {4'b0, s42};
  assign sm[3] = {4'b0, s44};

  int lat [4] = '{4, 4, 2, 1};

  typedef struct {
    int inst;
    int sum;
    bit cout;
    bit ovf;
    int acc;
  } exp_t;
  exp_t sb[$];

  int errs = 0;
  int nchk = 0;

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(int inst, int n, int a, int b, bit s, int acc);
    exp_t e;
    int m, r, sa, sb2, sr;
    m   = 1 << n;
    a   = a % m;
    b   = b % m;
    r   = s ? a - b : a + b;
    sa  = (a >= m / 2) ? a - m : a;
    sb2 = (b >= m / 2) ? b - m : b;
    sr  = s ? sa - sb2 : sa + sb2;
    e.inst = inst;
    e.sum  = ((r % m) + m) % m;
    e.cout = s ? (a >= b) : (r >= m);
    e.ovf  = (sr < -(m / 2)) || (sr >= m / 2);
    e.acc  = acc;
    return e;
  endfunction

  logic [3:0] prev_dn = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dn[i]) begin
        int idx;
        idx = -1;
        for (int j = 0; j < sb.size(); j++)
          if (idx < 0 && sb[j].inst == i) idx = j;
        chk($sformatf("done_width[%0d]", i), prev_dn[i], 0);
        chk($sformatf("busy_at_done[%0d]", i), bz[i], 0);
        if (idx < 0) begin
          chk($sformatf("unexpected_done[%0d]", i), 1, 0);
        end else begin
          chk($sformatf("sum[%0d]", i), sm[i], sb[idx].sum);
          chk($sformatf("cout[%0d]", i), co[i], sb[idx].cout);
          chk($sformatf("ovf[%0d]", i), ov[i], sb[idx].ovf);
          chk($sformatf("latency[%0d]", i), cyc - sb[idx].acc, lat[i]);
          sb.delete(idx);
        end
      end
    end
    prev_dn = dn;
  end

  task automatic issue8(logic [7:0] a, logic [7:0] b, logic s);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; st8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st8 = 1'b0;
    sb.push_back(model(0, 8, a, b, s, cyc));
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic issue4(logic [3:0] a, logic [3:0] b, logic s);
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; st4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st4 = 1'b0;
    for (int i = 1; i < 4; i++) sb.push_back(model(i, 4, a, b, s, cyc));
    a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", bz8, 0);
    chk("rst_done", dn8, 0);
    chk("rst_sum", s8, 0);
    chk("rst_cout", c8, 0);
    chk("rst_ovf", o8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, then random N=8 traffic with random gaps.
    issue8(8'h7F, 8'h01, 1'b0); drain(20);
    issue8(8'h05, 8'h07, 1'b1); drain(20);
    for (int k = 0; k < 30; k++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom));
      drain(20);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    issue8(8'hFF, 8'h01, 1'b0);
    drain(20);
    repeat (3) @(negedge clk);
    chk("hold_sum", s8, 8'h00);
    chk("hold_cout", c8, 1);
    chk("hold_busy", bz8, 0);

    // start held high: accepts only every 5 cycles, operands change every cycle.
    for (int k = 0; k < 20; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      st8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (k % 5 == 0) sb.push_back(model(0, 8, a8, b8, sub8, cyc));
    end
    st8 = 1'b0;
    drain(20);

    // Asynchronous reset in the middle of a run.
    issue8(8'hFF, 8'hFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bz8, 0);
    chk("arst_done", dn8, 0);
    chk("arst_sum", s8, 0);
    chk("arst_cout", c8, 0);
    chk("arst_ovf", o8, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue8(8'h10, 8'h20, 1'b0);
    drain(20);

    // Exhaustive N=4 on all three digit widths, random idle gaps.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int s = 0; s < 2; s++) begin
          issue4(4'(a), 4'(b), 1'(s));
          drain(20);
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
